aes_round_sequencer: RTL and testbench

Round scheduler for the AES encryption datapath. It sits behind the AHB-lite slave controller and runs after a plaintext block and key are loaded. It sequences the key-expansion, SubBytes, ShiftRows, MixColumns and AddRoundKey units through the initial round, the NUM_ROUNDS-1 full rounds and the final round, which has no MixColumns. It exposes a round index, a busy flag, a done pulse and a sticky timeout error.

---
 rtl/aes_round_sequencer.sv | 164 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Round scheduler for the AES encryption datapath. After a block and key are
// loaded, a start request walks the stage units through the initial
// AddRoundKey, NUM_ROUNDS-1 full rounds and a final round without MixColumns.
//
// Ports:
//   clk, n_rst               clock (rising edge), async active-low reset
//   start                    begin encryption (sampled only when idle)
//   abort                    synchronous abort back to idle
//   *_done                   stage-unit completion strobes
//   *_start                  one-cycle stage-unit start pulses
//   round                    current round index, 0..NUM_ROUNDS
//   busy                     high whenever not idle
//   done                     one-cycle completion pulse
//   error                    sticky stage-timeout flag
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned MAX_WAIT   = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       abort,
    input  logic       keyexp_done,
    input  logic       sbytes_done,
    input  logic       srows_done,
    input  logic       mcol_done,
    input  logic       ark_done,
    output logic       keyexp_start,
    output logic       sbytes_start,
    output logic       srows_start,
    output logic       mcol_start,
    output logic       ark_start,
    output logic [3:0] round,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // Wait counter is at least 8 bits, wider only if MAX_WAIT demands it.
    localparam int unsigned WaitW =
        ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);
    localparam logic [3:0]       LastRound = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        StIdle, StArk, StKeyex, StSbytes, StSrows, StMcol, StDone
    } state_e;

    state_e           state_q, state_d;
    logic             first_q, first_d;   // first cycle in the current state
    logic [3:0]       round_q, round_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             error_q, error_d;

    logic stage_done;
    logic in_stage;
    logic timeout;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            first_q <= 1'b0;
            round_q <= '0;
            wait_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            round_q <= round_d;
            wait_q  <= wait_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        wait_d     = wait_q;
        error_d    = error_q;
        stage_done = 1'b0;
        in_stage   = 1'b1;

        // Only the active stage's done strobe is looked at.
        unique case (state_q)
            StArk:    stage_done = ark_done;
            StKeyex:  stage_done = keyexp_done;
            StSbytes: stage_done = sbytes_done;
            StSrows:  stage_done = srows_done;
            StMcol:   stage_done = mcol_done;
            default:  in_stage   = 1'b0;
        endcase

        // A done on the start-pulse cycle is ignored.
        if (first_q) begin
            stage_done = 1'b0;
        end

        if (in_stage) begin
            if (first_q) begin
                wait_d = '0;
            end else if (!stage_done) begin
                wait_d = wait_q + 1'b1;
            end
        end

        timeout = in_stage && !first_q && !stage_done && (wait_q == WaitLast);

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StArk;
                    round_d = '0;
                    error_d = 1'b0;
                end
            end
            StArk: begin
                if (stage_done) begin
                    if (round_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        state_d = StKeyex;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            StKeyex:  if (stage_done) state_d = StSbytes;
            StSbytes: if (stage_done) state_d = StSrows;
            StSrows: begin
                // The final round skips MixColumns.
                if (stage_done) begin
                    state_d = (round_q == LastRound) ? StArk : StMcol;
                end
            end
            StMcol:   if (stage_done) state_d = StArk;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            round_d = '0;
        end else if (timeout) begin
            state_d = StIdle;
            error_d = 1'b1;
        end

        first_d = (state_d != state_q);
    end

    assign ark_start    = first_q && (state_q == StArk);
    assign keyexp_start = first_q && (state_q == StKeyex);
    assign sbytes_start = first_q && (state_q == StSbytes);
    assign srows_start  = first_q && (state_q == StSrows);
    assign mcol_start   = first_q && (state_q == StMcol);
    assign round        = round_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign error        = error_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for aes_round_sequencer. Instance A: NUM_ROUNDS=10, MAX_WAIT=4 with
// one-cycle stage stubs. Instance B: NUM_ROUNDS=14 with random 1..20 cycle
// stubs that also raise done on the start cycle.
// Stage bit order in the vectors: 0 keyexp, 1 sbytes, 2 srows, 3 mcol, 4 ark.
// -----------------------------------------------------------------------------
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    // Instance A
    logic       a_start = 1'b0, a_abort = 1'b0, a_stray = 1'b0;
    logic [4:0] a_dn = '0;
    logic [4:0] a_en = 5'b11111;
    wire  [4:0] a_st;
    wire  [3:0] a_round;
    wire        a_busy, a_done, a_err;
    int a_cnt[5] = '{default: 0};
    int a_tmr[5] = '{default: 0};
    int a_busy_cyc = 0, a_done_cnt = 0, a_mcol_final = 0;

    // Instance B
    logic       b_start = 1'b0, b_abort = 1'b0;
    logic [4:0] b_dn = '0;
    wire  [4:0] b_st;
    wire  [3:0] b_round;
    wire        b_busy, b_done, b_err;
    int b_cnt[5] = '{default: 0};
    int b_tmr[5] = '{default: 0};
    int b_busy_cyc = 0, b_done_cnt = 0, b_sum = 0;

    aes_round_sequencer #(.NUM_ROUNDS(10), .MAX_WAIT(4)) u_dut_a (
        .clk(clk), .n_rst(n_rst), .start(a_start), .abort(a_abort),
        .keyexp_done(a_dn[0]), .sbytes_done(a_dn[1]), .srows_done(a_dn[2]),
        .mcol_done(a_dn[3] | a_stray), .ark_done(a_dn[4]),
        .keyexp_start(a_st[0]), .sbytes_start(a_st[1]), .srows_start(a_st[2]),
        .mcol_start(a_st[3]), .ark_start(a_st[4]),
        .round(a_round), .busy(a_busy), .done(a_done), .error(a_err)
    );

    aes_round_sequencer #(.NUM_ROUNDS(14), .MAX_WAIT(255)) u_dut_b (
        .clk(clk), .n_rst(n_rst), .start(b_start), .abort(b_abort),
        .keyexp_done(b_dn[0]), .sbytes_done(b_dn[1]), .srows_done(b_dn[2]),
        .mcol_done(b_dn[3]), .ark_done(b_dn[4]),
        .keyexp_start(b_st[0]), .sbytes_start(b_st[1]), .srows_start(b_st[2]),
        .mcol_start(b_st[3]), .ark_start(b_st[4]),
        .round(b_round), .busy(b_busy), .done(b_done), .error(b_err)
    );

    // Stage stubs and monitors, evaluated mid-cycle.
    always @(negedge clk) begin
        for (int u = 0; u < 5; u++) begin
            if (a_st[u]) begin
                a_cnt[u]++;
                a_tmr[u] = 1;
                a_dn[u]  = 1'b0;
            end else if (a_tmr[u] > 0) begin
                a_tmr[u]--;
                a_dn[u] = (a_tmr[u] == 0) && a_en[u];
            end else begin
                a_dn[u] = 1'b0;
            end
        end
        if (a_busy) a_busy_cyc++;
        if (a_done) a_done_cnt++;
        if (a_st[3] && a_round == 4'd10) a_mcol_final++;

        for (int u = 0; u < 5; u++) begin
            if (b_st[u]) begin
                b_cnt[u]++;
                b_tmr[u] = $urandom_range(1, 20);
                b_sum   += b_tmr[u] + 1;
                b_dn[u]  = 1'b1;  // early done on the start cycle
            end else if (b_tmr[u] > 0) begin
                b_tmr[u]--;
                b_dn[u] = (b_tmr[u] == 0);
            end else begin
                b_dn[u] = 1'b0;
            end
        end
        if (b_busy) b_busy_cyc++;
        if (b_done) b_done_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start on A and return the offset of done (or -1 on timeout).
    task automatic run_a(output int off_done, output int err1);
        off_done = -1;
        err1     = -1;
        a_start  = 1'b1;
        for (int off = 0; off <= 300 && off_done < 0; off++) begin
            if (off == 1) begin
                a_start = 1'b0;
                err1    = a_err;
            end
            if (a_done) off_done = off;
            @(negedge clk);
        end
        a_start = 1'b0;
    endtask

    typedef struct {
        int         off;
        int         rnd;
        logic       bsy;
        logic       dn;
        logic [4:0] st;
    } vec_t;

    vec_t tbl[15];
    int   base[5];
    int   base_busy, base_done, base_sum;
    int   off_d, err1, idx;
    logic seen;

    initial begin
        tbl[0]  = '{0,   0,  1'b0, 1'b0, 5'b00000};
        tbl[1]  = '{1,   0,  1'b1, 1'b0, 5'b10000};
        tbl[2]  = '{2,   0,  1'b1, 1'b0, 5'b00000};
        tbl[3]  = '{3,   1,  1'b1, 1'b0, 5'b00001};
        tbl[4]  = '{9,   1,  1'b1, 1'b0, 5'b01000};
        tbl[5]  = '{11,  1,  1'b1, 1'b0, 5'b10000};
        tbl[6]  = '{13,  2,  1'b1, 1'b0, 5'b00001};
        tbl[7]  = '{53,  6,  1'b1, 1'b0, 5'b00001};
        tbl[8]  = '{89,  9,  1'b1, 1'b0, 5'b01000};
        tbl[9]  = '{93,  10, 1'b1, 1'b0, 5'b00001};
        tbl[10] = '{97,  10, 1'b1, 1'b0, 5'b00100};
        tbl[11] = '{99,  10, 1'b1, 1'b0, 5'b10000};
        tbl[12] = '{100, 10, 1'b1, 1'b0, 5'b00000};
        tbl[13] = '{101, 10, 1'b1, 1'b1, 5'b00000};
        tbl[14] = '{102, 10, 1'b0, 1'b0, 5'b00000};

        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset a busy", a_busy, 0);
        chk("reset a outs", {a_st, a_round, a_done, a_err}, 0);
        chk("reset b outs", {b_st, b_round, b_busy, b_done, b_err}, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run against the vector table.
        for (int u = 0; u < 5; u++) base[u] = a_cnt[u];
        base_busy = a_busy_cyc;
        base_done = a_done_cnt;
        idx = 0;
        a_start = 1'b1;
        for (int off = 0; off <= 105; off++) begin
            if (off == 1) a_start = 1'b0;
            if (idx < 15 && tbl[idx].off == off) begin
                chk($sformatf("vec%0d round", off), a_round, tbl[idx].rnd);
                chk($sformatf("vec%0d busy", off), a_busy, tbl[idx].bsy);
                chk($sformatf("vec%0d done", off), a_done, tbl[idx].dn);
                chk($sformatf("vec%0d starts", off), a_st, tbl[idx].st);
                idx++;
            end
            @(negedge clk);
        end
        chk("nom keyexp count", a_cnt[0] - base[0], 10);
        chk("nom sbytes count", a_cnt[1] - base[1], 10);
        chk("nom srows count",  a_cnt[2] - base[2], 10);
        chk("nom mcol count",   a_cnt[3] - base[3], 9);
        chk("nom ark count",    a_cnt[4] - base[4], 11);
        chk("nom busy cycles",  a_busy_cyc - base_busy, 101);
        chk("nom done pulses",  a_done_cnt - base_done, 1);
        chk("nom final mcol",   a_mcol_final, 0);

        // Timeout: SubBytes never answers.
        a_en[1]   = 1'b0;
        base_done = a_done_cnt;
        a_start   = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        seen    = a_st[1];
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = a_st[1];
        end
        chk("to sbytes_start seen", seen, 1);
        repeat (4) @(negedge clk);
        chk("to S+4 busy", a_busy, 1);
        chk("to S+4 error", a_err, 0);
        @(negedge clk);
        chk("to S+5 busy", a_busy, 0);
        chk("to S+5 error", a_err, 1);
        repeat (3) @(negedge clk);
        chk("to error sticky", a_err, 1);
        chk("to no done", a_done_cnt - base_done, 0);
        a_en[1] = 1'b1;
        run_a(off_d, err1);
        chk("to recovery latency", off_d, 101);
        chk("to error cleared", err1, 0);
        repeat (2) @(negedge clk);

        // Stray mcol_done while KEYEX waits, then abort out.
        a_en[0] = 1'b0;
        a_start = 1'b1;
        for (int off = 0; off <= 8; off++) begin
            if (off == 1) a_start = 1'b0;
            a_stray = (off >= 4 && off <= 6);
            if (off == 7) begin
                chk("stray round", a_round, 1);
                chk("stray starts", a_st, 0);
                chk("stray busy", a_busy, 1);
                a_abort = 1'b1;
            end
            if (off == 8) begin
                chk("stray abort busy", a_busy, 0);
                a_abort = 1'b0;
            end
            @(negedge clk);
        end
        a_stray = 1'b0;
        a_en[0] = 1'b1;
        repeat (4) @(negedge clk);

        // Abort in round 5 MCOL, with start held high while busy.
        base_done = a_done_cnt;
        a_start = 1'b1;
        for (int off = 0; off <= 50; off++) begin
            a_start = (off == 0) || (off >= 20 && off <= 30);
            if (off == 49) begin
                chk("abort pre round", a_round, 5);
                chk("abort pre starts", a_st, 5'b01000);
                a_abort = 1'b1;
            end
            if (off == 50) begin
                chk("abort busy", a_busy, 0);
                chk("abort round", a_round, 0);
                a_abort = 1'b0;
            end
            @(negedge clk);
        end
        a_start = 1'b0;
        repeat (120) @(negedge clk);
        chk("abort no done", a_done_cnt - base_done, 0);
        chk("abort still idle", a_busy, 0);

        // Asynchronous reset in round 3 SROWS.
        a_start = 1'b1;
        for (int off = 0; off <= 27; off++) begin
            if (off == 1) a_start = 1'b0;
            if (off == 27) begin
                chk("rst pre round", a_round, 3);
                chk("rst pre starts", a_st, 5'b00100);
            end
            if (off < 27) @(negedge clk);
        end
        #2 n_rst = 1'b0;
        #1;
        chk("async rst busy", a_busy, 0);
        chk("async rst outs", {a_st, a_round, a_done, a_err}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        run_a(off_d, err1);
        chk("rst recovery latency", off_d, 101);

        // Variable latency on the 14-round instance.
        for (int u = 0; u < 5; u++) base[u] = b_cnt[u];
        base_busy = b_busy_cyc;
        base_done = b_done_cnt;
        base_sum  = b_sum;
        seen      = 1'b0;
        b_start   = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            seen = b_done;
            @(negedge clk);
        end
        chk("var done seen", seen, 1);
        repeat (2) @(negedge clk);
        chk("var keyexp count", b_cnt[0] - base[0], 14);
        chk("var sbytes count", b_cnt[1] - base[1], 14);
        chk("var srows count",  b_cnt[2] - base[2], 14);
        chk("var mcol count",   b_cnt[3] - base[3], 13);
        chk("var ark count",    b_cnt[4] - base[4], 15);
        chk("var done pulses",  b_done_cnt - base_done, 1);
        chk("var busy cycles",  b_busy_cyc - base_busy, b_sum - base_sum + 1);
        chk("var round hold",   b_round, 14);
        chk("var error",        b_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
